// File: rtl/div_sched_if.sv
// Request, divider and response signal bundle for div_sched.
// slave is the scheduler side; master is the EX/divider/writeback side.
interface div_sched_if #(
   parameter int unsigned TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic [TAG_W-1:0] req_tag;

   logic             div_start;
   logic [31:0]      div_remainder;
   logic [31:0]      div_divisor;
   logic [2:0]       div_ctrl;
   logic [31:0]      div_out;
   logic             div_done;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic [TAG_W-1:0] rsp_tag;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_tag, div_out, div_done, rsp_ready,
      output req_ready, div_start, div_remainder, div_divisor, div_ctrl,
             rsp_valid, rsp_data, rsp_tag
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_tag, div_out, div_done, rsp_ready,
      input  req_ready, div_start, div_remainder, div_divisor, div_ctrl,
             rsp_valid, rsp_data, rsp_tag
   );
endinterface

// File: rtl/div_sched.sv
// Issue/completion controller for the fixed-latency pipelined divider: reserves a result slot
// per op, pairs div_done results with tags in order and drains them to writeback.
module div_sched #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TAG_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   div_sched_if.slave bus,
   output logic       busy,
   output logic       err
);
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CountMax = CntW'(DEPTH);

   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] killed_q;
   logic [DEPTH-1:0] filled_q;

   logic [PtrW-1:0] alloc_q, alloc_d;
   logic [PtrW-1:0] fill_q, fill_d;
   logic [PtrW-1:0] head_q, head_d;
   logic [CntW-1:0] count_q, count_d;

   logic        div_start_q;
   logic [31:0] div_rem_q;
   logic [31:0] div_dvs_q;
   logic [2:0]  div_ctrl_q;
   logic        err_q, err_d;

   logic req_ready;
   logic accept;
   logic head_filled;
   logic head_killed;
   logic rsp_valid;
   logic pop;
   logic done_ok;

   always_comb begin
      req_ready   = !rst && !flush && (count_q < CountMax);
      accept      = bus.req_valid && req_ready;
      head_filled = filled_q[head_q];
      head_killed = killed_q[head_q];
      rsp_valid   = !rst && !flush && head_filled && !head_killed;
      // Killed results leave silently; live ones need the writeback handshake.
      pop         = head_filled && (head_killed || (rsp_valid && bus.rsp_ready));
      // fill == alloc is ambiguous when every slot is reserved and none has completed yet.
      done_ok     = bus.div_done && !filled_q[fill_q] &&
                    ((fill_q != alloc_q) || (count_q == CountMax));

      alloc_d = accept  ? alloc_q + PtrW'(1) : alloc_q;
      fill_d  = done_ok ? fill_q + PtrW'(1)  : fill_q;
      head_d  = pop     ? head_q + PtrW'(1)  : head_q;
      count_d = count_q + CntW'(accept) - CntW'(pop);
      err_d   = err_q || (bus.div_done && !done_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alloc_q     <= '0;
         fill_q      <= '0;
         head_q      <= '0;
         count_q     <= '0;
         killed_q    <= '0;
         filled_q    <= '0;
         div_start_q <= 1'b0;
         div_rem_q   <= '0;
         div_dvs_q   <= '0;
         div_ctrl_q  <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         alloc_q     <= alloc_d;
         fill_q      <= fill_d;
         head_q      <= head_d;
         count_q     <= count_d;
         err_q       <= err_d;
         div_start_q <= accept;

         // Unallocated slots may be marked too: an accept always clears the bit it reuses.
         if (flush) begin
            killed_q <= '1;
         end
         if (accept) begin
            div_rem_q          <= bus.req_a;
            div_dvs_q          <= bus.req_b;
            div_ctrl_q         <= bus.req_op;
            tag_q[alloc_q]     <= bus.req_tag;
            killed_q[alloc_q]  <= 1'b0;
            filled_q[alloc_q]  <= 1'b0;
         end
         if (done_ok) begin
            data_q[fill_q]   <= bus.div_out;
            filled_q[fill_q] <= 1'b1;
         end
         if (pop) begin
            filled_q[head_q] <= 1'b0;
         end
      end
   end

   assign bus.req_ready     = req_ready;
   assign bus.div_start     = div_start_q;
   assign bus.div_remainder = div_rem_q;
   assign bus.div_divisor   = div_dvs_q;
   assign bus.div_ctrl      = div_ctrl_q;
   assign bus.rsp_valid     = rsp_valid;
   assign bus.rsp_data      = data_q[head_q];
   assign bus.rsp_tag       = tag_q[head_q];
   assign busy              = (count_q != '0);
   assign err               = err_q;
endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: an 18-stage divider model answers div_start, a monitor pops
// expected {tag, data} at every handshake and clears them on flush.
module tb_div_sched;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned TAG_W = 5;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
   } exp_t;

   typedef struct {
      int          t;
      logic [31:0] v;
   } dv_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic busy;
   logic err;
   logic spur = 1'b0;
   logic model_done = 1'b0;
   logic [31:0] model_out = '0;

   int n_cmp = 0;
   int n_bad = 0;
   exp_t exp_q[$];
   dv_t  dq[$];
   bit   rand_on = 1'b0;

   always #5 clk = ~clk;

   div_sched_if #(.TAG_W(TAG_W)) bus ();

   div_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus),
      .busy  (busy),
      .err   (err)
   );

   assign bus.div_done = model_done | spur;
   assign bus.div_out  = spur ? 32'hDEAD_BEEF : model_out;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // RISC-V style DIV/DIVU/REM/REMU: bit0 unsigned, bit1 remainder.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
         return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return op[1] ? a % b : a / b;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom();
      endcase
   endfunction

   // Divider: result presented 18 cycles after the cycle in which div_start is high.
   initial begin
      int cyc = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            dq.delete();
         end else if (bus.div_start) begin
            dv_t d;
            d.t = cyc + 18;
            d.v = ref_div(bus.div_remainder, bus.div_divisor, bus.div_ctrl);
            dq.push_back(d);
         end
         @(posedge clk);
         #1;
         cyc++;
         if (dq.size() > 0 && dq[0].t == cyc) begin
            model_done = 1'b1;
            model_out  = dq[0].v;
            dq.delete(0);
         end else begin
            model_done = 1'b0;
            model_out  = $urandom();
         end
      end
   end

   // Monitor: scoreboard pop, div_start pulse and response stability.
   initial begin
      bit               acc_prev = 1'b0;
      bit               hold = 1'b0;
      logic [31:0]      hold_data = '0;
      logic [TAG_W-1:0] hold_tag = '0;
      exp_t             e;
      forever begin
         @(negedge clk);
         if (rst) begin
            acc_prev = 1'b0;
            hold     = 1'b0;
         end else begin
            check("div_start", 32'(bus.div_start), 32'(acc_prev));
            acc_prev = bus.req_valid && bus.req_ready;
            if (hold && !flush) begin
               check("hold_valid", 32'(bus.rsp_valid), 32'd1);
               check("hold_data", bus.rsp_data, hold_data);
               check("hold_tag", 32'(bus.rsp_tag), 32'(hold_tag));
            end
            hold      = bus.rsp_valid && !bus.rsp_ready && !flush;
            hold_data = bus.rsp_data;
            hold_tag  = bus.rsp_tag;
            if (flush) begin
               check("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
               exp_q.delete();
            end else if (bus.rsp_valid && bus.rsp_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_rsp: got tag %0d data %h want no response",
                           bus.rsp_tag, bus.rsp_data);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_data", bus.rsp_data, e.data);
                  check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
               end
            end
         end
      end
   end

   // Random writeback backpressure during the random phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_on) bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // All stimulus tasks start and end just after a rising edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp);
      bit   done = 1'b0;
      exp_t e;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_op    = op;
      bus.req_tag   = tag;
      bus.req_valid = 1'b1;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            e.tag  = tag;
            e.data = exp;
            exp_q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: tag %0d not accepted, want accept within 300 cycles", tag);
         bus.req_valid = 1'b0;
      end
   endtask

   task automatic wait_latency(input string name, input int want);
      int lat = 0;
      for (int k = 1; k <= 100 && lat == 0; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) lat = k;
      end
      @(posedge clk);
      #1;
      check(name, 32'(lat), 32'(want));
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 400; k++) begin
         if (exp_q.size() == 0 && !busy) break;
         @(posedge clk);
         #1;
      end
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      logic [31:0] a, b;
      logic [2:0] op;
      rst           = 1'b1;
      flush         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      bus.req_tag   = '0;
      bus.rsp_ready = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_div_start", 32'(bus.div_start), 32'd0);
      check("rst_div_rem", bus.div_remainder, 32'd0);
      check("rst_div_dvs", bus.div_divisor, 32'd0);
      check("rst_div_ctrl", 32'(bus.div_ctrl), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data", bus.rsp_data, 32'd0);
      check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;

      // Single signed divide and its minimum latency.
      bus.rsp_ready = 1'b1;
      send(32'hFFFF_FFF9, 32'd2, 3'b000, 5'd3, 32'hFFFF_FFFD);
      bus.req_valid = 1'b0;
      wait_latency("lat_div", 20);
      drain("div");

      // Back-to-back REM, DIVU, divide-by-zero.
      send(32'hFFFF_FFF9, 32'd2, 3'b010, 5'd4, 32'hFFFF_FFFF);
      send(32'hFFFF_FFF9, 32'd2, 3'b001, 5'd5, 32'h7FFF_FFFC);
      send(32'd5, 32'd0, 3'b000, 5'd6, 32'hFFFF_FFFF);
      bus.req_valid = 1'b0;
      drain("b2b");

      // Buffer full with writeback stalled.
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         send(32'(100 + i), 32'd3, 3'b101, 5'(10 + i), 32'((100 + i) / 3));
      end
      bus.req_a     = 32'd77;
      bus.req_b     = 32'd7;
      bus.req_op    = 3'b001;
      bus.req_tag   = 5'd31;
      bus.req_valid = 1'b1;
      repeat (25) @(negedge clk);
      check("full_req_ready", 32'(bus.req_ready), 32'd0);
      check("full_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("full_hs_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("ninth_req_ready", 32'(bus.req_ready), 32'd1);
      if (bus.req_ready) begin
         exp_t e;
         e.tag  = 5'd31;
         e.data = 32'd11;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      drain("full");

      // Flush three in-flight ops, then issue tag 7.
      send(32'd40, 32'd5, 3'b000, 5'd1, 32'd8);
      send(32'd41, 32'd5, 3'b010, 5'd2, 32'd1);
      send(32'd42, 32'd5, 3'b001, 5'd26, 32'd8);
      bus.req_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(negedge clk);
      check("flush_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      send(32'd1000, 32'd10, 3'b000, 5'd7, 32'd100);
      bus.req_valid = 1'b0;
      wait_latency("lat_after_flush", 20);
      drain("flush");

      // Flush coinciding with a would-be handshake.
      bus.rsp_ready = 1'b0;
      send(32'd100, 32'd7, 3'b001, 5'd9, 32'd14);
      bus.req_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         seen = bus.rsp_valid;
      end
      check("flush_hs_rsp_seen", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      flush         = 1'b1;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      repeat (3) @(negedge clk);
      check("flush_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("flush_hs_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // Random traffic with backpressure and occasional flushes.
      rand_on = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            bus.req_valid = 1'b0;
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
         end
         if ($urandom_range(0, 2) == 0) begin
            bus.req_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
            end
         end
         a  = pick();
         b  = pick();
         op = 3'($urandom_range(0, 7));
         send(a, b, op, 5'($urandom_range(0, 31)), ref_div(a, b, op));
      end
      bus.req_valid = 1'b0;
      rand_on = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      drain("rand");
      check("rand_err", 32'(err), 32'd0);

      // Spurious completion with nothing outstanding.
      spur = 1'b1;
      @(posedge clk);
      #1;
      spur = 1'b0;
      @(negedge clk);
      check("spur_err", 32'(err), 32'd1);
      repeat (10) @(negedge clk);
      check("spur_err_sticky", 32'(err), 32'd1);
      check("spur_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("spur_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst2_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst2_err", 32'(err), 32'd0);
      check("rst2_req_ready_up", 32'(bus.req_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
